// File: rtl/simple_cpu_pkg.sv
// Shared constants for the simple CPU: word width, instruction formats,
// function codes and one-hot phase encodings.
package simple_cpu_pkg;

   localparam int unsigned WORD_WIDTH = 16;

   typedef enum logic [1:0] {
      FMT_LOAD   = 2'b00,
      FMT_STORE  = 2'b01,
      FMT_IMM_BR = 2'b10,
      FMT_CALC   = 2'b11
   } fmt_e;

   localparam logic [3:0] FUNCT_ADD  = 4'b0000;
   localparam logic [3:0] FUNCT_SUB  = 4'b0001;
   localparam logic [3:0] FUNCT_AND  = 4'b0010;
   localparam logic [3:0] FUNCT_OR   = 4'b0011;
   localparam logic [3:0] FUNCT_XOR  = 4'b0100;
   localparam logic [3:0] FUNCT_IN   = 4'b1100;
   localparam logic [3:0] FUNCT_OUT  = 4'b1101;
   localparam logic [3:0] FUNCT_HALT = 4'b1111;

   localparam logic [4:0] P1 = 5'b00001;
   localparam logic [4:0] P2 = 5'b00010;
   localparam logic [4:0] P3 = 5'b00100;
   localparam logic [4:0] P4 = 5'b01000;
   localparam logic [4:0] P5 = 5'b10000;

   function automatic logic is_out_instr(input fmt_e fmt, input logic [3:0] funct);
      return (fmt == FMT_CALC) && (funct == FUNCT_OUT);
   endfunction

endpackage

// File: rtl/out_port_buffer_if.sv
// Controller/sink-facing signal bundle of the OUT port buffer.
interface out_port_if import simple_cpu_pkg::*; #(
   parameter int unsigned WIDTH = WORD_WIDTH,
   parameter int unsigned DEPTH = 8
) ();
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             stall;
   logic             tx_valid;
   logic [WIDTH-1:0] tx_data;
   logic             tx_ready;
   logic [WIDTH-1:0] display;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             clear_overflow;

   modport master (
      output out_valid, out_data, tx_ready, clear_overflow,
      input  stall, tx_valid, tx_data, display, count, overflow
   );

   modport slave (
      input  out_valid, out_data, tx_ready, clear_overflow,
      output stall, tx_valid, tx_data, display, count, overflow
   );
endinterface

// File: rtl/out_port_buffer_sync_fifo.sv
// Synchronous FIFO with count-based full/empty; head is read from registered state.
module sync_fifo import simple_cpu_pkg::*; #(
   parameter int unsigned WIDTH = WORD_WIDTH,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;

   assign w_pop   = i_pop && !o_empty;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         // When full, wr_ptr equals rd_ptr: a push here only lands together with a pop of that slot.
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/out_port_buffer.sv
// OUT port buffer: queues OUT words toward a valid/ready sink, keeps the last
// accepted word for display, stalls the controller when full.
module out_port_buffer import simple_cpu_pkg::*; #(
   parameter int unsigned WIDTH = WORD_WIDTH,
   parameter int unsigned DEPTH = 8
) (
   input  logic      clock,
   input  logic      reset_n,
   out_port_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [CW-1:0]    w_count;
   logic [WIDTH-1:0] w_head;
   logic [WIDTH-1:0] r_display;
   logic             r_overflow;

   assign w_pop  = !w_empty && bus.tx_ready;
   assign w_push = bus.out_valid && (!w_full || w_pop);

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk     (clock),
      .rst_n   (reset_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (bus.out_data),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_display  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_display <= bus.out_data;
         if (bus.out_valid && !w_push) r_overflow <= 1'b1;
         else if (bus.clear_overflow)  r_overflow <= 1'b0;
      end
   end

   assign bus.stall    = w_full;
   assign bus.tx_valid = !w_empty;
   assign bus.tx_data  = w_head;
   assign bus.display  = r_display;
   assign bus.count    = w_count;
   assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_out_port_buffer.sv
// Randomized and directed bench for out_port_buffer against a queue-based model.
module tb_out_port_buffer;
   import simple_cpu_pkg::*;

   localparam int unsigned W = 16;
   localparam int unsigned D = 8;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [W-1:0] m_q[$];
   logic [W-1:0] m_disp;
   logic         m_ovf;

   out_port_if #(.WIDTH(W), .DEPTH(D)) bus ();

   out_port_buffer #(.WIDTH(W), .DEPTH(D)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all(input string tag);
      logic [W-1:0] head;
      head = (m_q.size() > 0) ? m_q[0] : '0;
      chk({tag, "_count"},    32'(bus.count), 32'(m_q.size()));
      chk({tag, "_txvalid"},  32'(bus.tx_valid), 32'(m_q.size() > 0));
      chk({tag, "_txdata"},   32'(bus.tx_data), 32'(head));
      chk({tag, "_display"},  32'(bus.display), 32'(m_disp));
      chk({tag, "_overflow"}, 32'(bus.overflow), 32'(m_ovf));
      chk({tag, "_stall"},    32'(bus.stall), 32'(m_q.size() == D));
   endtask

   // Called at a negedge: drive inputs, advance model across the next posedge, check.
   task automatic step(input string tag, input logic ov, input logic [W-1:0] od,
                       input logic rdy, input logic clr);
      bit pop, push;
      bus.out_valid      = ov;
      bus.out_data       = od;
      bus.tx_ready       = rdy;
      bus.clear_overflow = clr;
      pop  = (m_q.size() > 0) && rdy;
      push = ov && ((m_q.size() < D) || pop);
      @(posedge clk);
      if (pop) void'(m_q.pop_front());
      if (push) begin
         m_q.push_back(od);
         m_disp = od;
      end
      if (ov && !push) m_ovf = 1'b1;
      else if (clr)    m_ovf = 1'b0;
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 2 * D && m_q.size() > 0; k++) step(tag, 1'b0, '0, 1'b1, 1'b0);
      chk({tag, "_empty"}, 32'(bus.count), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data = '0;
      bus.tx_ready = 1'b0;
      bus.clear_overflow = 1'b0;
      m_q.delete();
      m_disp = '0;
      m_ovf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      compare_all("reset");
      rst_n = 1'b1;

      // Single push, then single pop
      step("p1", 1'b1, 16'h0004, 1'b0, 1'b0);
      chk("p1_data_const", 32'(bus.tx_data), 32'h0004);
      chk("p1_disp_const", 32'(bus.display), 32'h0004);
      step("p1pop", 1'b0, '0, 1'b1, 1'b0);
      chk("p1pop_valid_const", 32'(bus.tx_valid), 32'd0);

      // Fill, then overflow
      for (int i = 1; i <= 8; i++) step("fill", 1'b1, 16'(i), 1'b0, 1'b0);
      chk("fill_stall_const", 32'(bus.stall), 32'd1);
      step("ovf", 1'b1, 16'h0009, 1'b0, 1'b0);
      chk("ovf_flag_const", 32'(bus.overflow), 32'd1);
      chk("ovf_disp_const", 32'(bus.display), 32'h0008);

      // Clear, then simultaneous push/pop while full
      step("clr", 1'b0, '0, 1'b0, 1'b1);
      step("fullpp", 1'b1, 16'h00AA, 1'b1, 1'b0);
      chk("fullpp_count_const", 32'(bus.count), 32'd8);
      chk("fullpp_ovf_const", 32'(bus.overflow), 32'd0);
      chk("fullpp_head_const", 32'(bus.tx_data), 32'h0002);
      drain("drain1");

      // Overflow set beats clear in the same cycle
      for (int i = 0; i < 8; i++) step("fill2", 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
      step("ovf2", 1'b1, 16'h0055, 1'b0, 1'b0);
      step("setclr", 1'b1, 16'h0066, 1'b0, 1'b1);
      chk("setclr_const", 32'(bus.overflow), 32'd1);
      step("clronly", 1'b0, '0, 1'b0, 1'b1);
      chk("clronly_const", 32'(bus.overflow), 32'd0);
      drain("drain2");

      // Random traffic across pointer wrap
      for (int i = 0; i < 400; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0));
         chk("rand_bound", 32'(bus.count <= D), 32'd1);
      end
      drain("drain3");

      // Asynchronous reset in mid-cycle with words queued
      for (int i = 0; i < 5; i++) step("q5", 1'b1, 16'(16'h0A00 + i), 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.out_valid = 1'b0;
      #1;
      m_q.delete();
      m_disp = '0;
      m_ovf = 1'b0;
      compare_all("arst");
      @(negedge clk);
      rst_n = 1'b1;
      step("post", 1'b1, 16'h1234, 1'b0, 1'b0);
      chk("post_data_const", 32'(bus.tx_data), 32'h1234);
      chk("post_valid_const", 32'(bus.tx_valid), 32'd1);
      drain("drain4");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
